// File: rtl/snn_enc_pkg.sv
// Package: snn_enc_pkg
// Purpose : shared types and constants for the spike rate encoder slice.
//   - enc_state_t : frame sequencer states (IDLE -> RUN -> DONE -> IDLE)
//   - DEF_NUM_CH / DEF_INT_W : default channel count and intensity width
//   - LFSR_TAPS : Fibonacci tap mask (taps 16,14,13,11) for the optional
//                 phase LFSR used when SPIKE_PHASE_EN is defined
//   - lfsrStep / rotateRight : helpers for the phase LFSR
package snn_enc_pkg;

    localparam int DEF_NUM_CH = 16;
    localparam int DEF_INT_W  = 4;

    // Bit n-1 set for tap n.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } enc_state_t;

    function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [15:0] rotateRight(input logic [15:0] val, input int amt);
        int sh;
        sh = amt % 16;
        return (val >> sh) | (val << (16 - sh));
    endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Interface: spike_rate_encoder_if
// Purpose : host-side load/control handshake plus the presynaptic spike bus.
//   master (host / bench) drives : load_valid, load_ch, load_intensity, start, halt
//   master observes              : load_ready, busy, frame_done, spike_out
//   slave  (encoder) is the mirror image.
interface spike_rate_encoder_if
    import snn_enc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int INT_W  = DEF_INT_W
);
    logic                      load_valid;
    logic                      load_ready;
    logic [$clog2(NUM_CH)-1:0] load_ch;
    logic [INT_W-1:0]          load_intensity;
    logic                      start;
    logic                      halt;
    logic                      busy;
    logic                      frame_done;
    logic [NUM_CH-1:0]         spike_out;

    modport master (
        output load_valid, load_ch, load_intensity, start, halt,
        input  load_ready, busy, frame_done, spike_out
    );

    modport slave (
        input  load_valid, load_ch, load_intensity, start, halt,
        output load_ready, busy, frame_done, spike_out
    );
endinterface

// File: rtl/enc_channel.sv
// Module : enc_channel
// Purpose: one rate-coding channel -- an INT_W-bit phase accumulator and its
//          registered spike. Each step adds the intensity; the carry out of
//          the INT_W-bit sum is the spike and the accumulator keeps the
//          remainder, so exactly `intensity` spikes occur per 2**INT_W steps.
// Ports  : clock, reset (async, active-high)
//          init      - load accumulator with initAcc, clear spike (frame start)
//          step      - accumulate one RUN cycle
//          initAcc   - starting phase for the accumulator
//          intensity - channel intensity
//          spike     - registered spike (cleared whenever not stepping)
module enc_channel
    import snn_enc_pkg::*;
#(
    parameter int INT_W = DEF_INT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             init,
    input  logic             step,
    input  logic [INT_W-1:0] initAcc,
    input  logic [INT_W-1:0] intensity,
    output logic             spike
);
    logic [INT_W-1:0] acc;
    logic [INT_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, intensity};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            spike <= 1'b0;
        end else if (init) begin
            acc   <= initAcc;
            spike <= 1'b0;
        end else if (step) begin
            // Dropping the carry is the subtract-threshold wrap.
            acc   <= sum[INT_W-1:0];
            spike <= sum[INT_W];
        end else begin
            spike <= 1'b0;
        end
    end
endmodule

// File: rtl/spike_rate_encoder.sv
// Module : spike_rate_encoder
// Purpose: converts per-channel intensities into rate-coded presynaptic spike
//          trains; intensity I yields exactly I spikes per frame.
// Ports  : clock, reset (async, active-high)
//          bus (spike_rate_encoder_if.slave):
//            load_valid/load_ready/load_ch/load_intensity - intensity writes (IDLE only)
//            start      - begin a frame (IDLE only)
//            halt       - abort a running frame, no frame_done
//            busy       - high while in RUN
//            frame_done - one-cycle pulse in DONE
//            spike_out  - registered spikes, one bit per channel
// Timing : the start edge enters RUN; the next FRAME_LEN edges accumulate,
//          so spikes are visible on RUN cycles 1..FRAME_LEN counted from the
//          cycle after RUN is entered. The following edge enters DONE, where
//          frame_done is high and spike_out is 0.
// Config : define SPIKE_PHASE_EN to seed each accumulator from a rotated
//          slice of a 16-bit LFSR at frame start (decorrelated timing,
//          unchanged spike counts). Undefined: accumulators start at 0.
module spike_rate_encoder
    import snn_enc_pkg::*;
#(
    parameter int          NUM_CH    = DEF_NUM_CH,
    parameter int          INT_W     = DEF_INT_W,
    parameter int          FRAME_LEN = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic                 clock,
    input logic                 reset,
    spike_rate_encoder_if.slave bus
);
    localparam logic [INT_W:0] FRAME_END = (INT_W + 1)'(FRAME_LEN);

    enc_state_t        state;
    logic [INT_W:0]    cycleCnt;
    logic              busyReg;
    logic              doneReg;
    logic [INT_W-1:0]  intensity [NUM_CH];
    logic [NUM_CH-1:0] spikeVec;

    logic loadFire;
    logic startFrame;
    logic stepRun;

    assign bus.load_ready = (state == IDLE) && !reset;
    assign loadFire       = bus.load_valid && bus.load_ready;
    assign startFrame     = (state == IDLE) && bus.start;
    assign stepRun        = (state == RUN) && !bus.halt && (cycleCnt < FRAME_END);

    assign bus.busy       = busyReg;
    assign bus.frame_done = doneReg;
    assign bus.spike_out  = spikeVec;

    // NOTE: the intensity file is reset element by element so that a frame
    // started after reset is silent; this keeps it out of RAM inference.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) intensity[i] <= '0;
        end else if (loadFire) begin
            intensity[bus.load_ch] <= bus.load_intensity;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cycleCnt <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        cycleCnt <= '0;
                        busyReg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else if (cycleCnt == FRAME_END) begin
                        state   <= DONE;
                        busyReg <= 1'b0;
                        doneReg <= 1'b1;
                    end else begin
                        cycleCnt <= cycleCnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPIKE_PHASE_EN
    logic [15:0] lfsr;

    // The current value seeds this frame's phases; the step readies the next.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           lfsr <= LFSR_SEED;
        else if (startFrame) lfsr <= lfsrStep(lfsr);
    end
`endif

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : gChan
        logic [INT_W-1:0] phase;
`ifdef SPIKE_PHASE_EN
        logic [15:0] rotated;
        assign rotated = rotateRight(lfsr, ch);
        assign phase   = rotated[INT_W-1:0];
`else
        assign phase = '0;
`endif
        enc_channel #(.INT_W(INT_W)) uChan (
            .clock     (clock),
            .reset     (reset),
            .init      (startFrame),
            .step      (stepRun),
            .initAcc   (phase),
            .intensity (intensity[ch]),
            .spike     (spikeVec[ch])
        );
    end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder (16 channels, 4-bit intensity).
// Spike trains are stored per channel as 16-bit masks, bit k-1 = RUN cycle k.
module tb_spike_rate_encoder;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    logic [15:0] trains [16];

    spike_rate_encoder_if #(.NUM_CH(16), .INT_W(4)) bus ();

    spike_rate_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic loadCh(input int ch, input int val);
        bus.load_valid     = 1'b1;
        bus.load_ch        = 4'(ch);
        bus.load_intensity = 4'(val);
        tick();
        bus.load_valid = 1'b0;
    endtask

    // Exact positions in the deterministic build, counts with phase offsets.
    task automatic checkTrain(input string tag, input int ch, input logic [15:0] expMask, input int inten);
`ifdef SPIKE_PHASE_EN
        check(tag, $countones(trains[ch]), inten);
`else
        check(tag, trains[ch], expMask);
        check({tag, "_n"}, $countones(trains[ch]), inten);
`endif
    endtask

    // Issues start (plus any load the caller already set up), records
    // RUN cycles 1..16 and checks the DONE cycle and the return to IDLE.
    // A load and a second start are driven mid-frame and must be ignored.
    task automatic runFrame(input string tag);
        logic doneSeen;
        doneSeen = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        check({tag, "_busy0"}, bus.busy, 1'b1);
        check({tag, "_ready0"}, bus.load_ready, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 1) begin
                bus.load_valid     = 1'b1;
                bus.load_ch        = 4'd5;
                bus.load_intensity = 4'd15;
                bus.start          = 1'b1;
            end
            tick();
            bus.load_valid = 1'b0;
            bus.start      = 1'b0;
            for (int ch = 0; ch < 16; ch++) trains[ch][k-1] = bus.spike_out[ch];
            doneSeen = doneSeen | bus.frame_done;
            if (k == 16) check({tag, "_busy16"}, bus.busy, 1'b1);
        end
        check({tag, "_early_done"}, doneSeen, 1'b0);
        tick();
        check({tag, "_done"}, bus.frame_done, 1'b1);
        check({tag, "_done_spk"}, bus.spike_out, 16'h0);
        check({tag, "_done_busy"}, bus.busy, 1'b0);
        tick();
        check({tag, "_done_pulse"}, bus.frame_done, 1'b0);
        check({tag, "_idle_ready"}, bus.load_ready, 1'b1);
    endtask

    task automatic checkTest1(input string tag);
        checkTrain({tag, "_ch1"}, 1, 16'hAAAA, 8);
        checkTrain({tag, "_ch2"}, 2, 16'hFFFE, 15);
        checkTrain({tag, "_ch3"}, 3, 16'h8000, 1);
        checkTrain({tag, "_ch0"}, 0, 16'h0000, 0);
        checkTrain({tag, "_ch5"}, 5, 16'h0000, 0);
    endtask

    function automatic logic [15:0] orTrains();
        logic [15:0] acc;
        acc = '0;
        for (int ch = 0; ch < 16; ch++) acc |= trains[ch];
        return acc;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset              = 1'b1;
        bus.load_valid     = 1'b0;
        bus.load_ch        = '0;
        bus.load_intensity = '0;
        bus.start          = 1'b0;
        bus.halt           = 1'b0;

        // Reset state.
        repeat (2) tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.frame_done, 1'b0);
        check("rst_spk", bus.spike_out, 16'h0);
        check("rst_ready", bus.load_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("rel_ready", bus.load_ready, 1'b1);
        tick();

        // Test 1: three channels at 8, 15, 1.
        loadCh(1, 8);
        loadCh(2, 15);
        loadCh(3, 1);
        runFrame("t1");
        checkTest1("t1");
`ifdef SPIKE_PHASE_EN
        check("t1_phase_moved",
              (trains[1] != 16'hAAAA) || (trains[2] != 16'hFFFE) || (trains[3] != 16'h8000), 1'b1);
`endif

        // Test 4: halt at RUN cycle 5, then restart.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("t4_busy5", bus.busy, 1'b1);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("t4_halt_busy", bus.busy, 1'b0);
        check("t4_halt_spk", bus.spike_out, 16'h0);
        check("t4_halt_ready", bus.load_ready, 1'b1);
        check("t4_halt_done", bus.frame_done, 1'b0);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("t4_idle_halt", bus.busy, 1'b0);
        check("t4_no_done", bus.frame_done, 1'b0);
        runFrame("t4r");
        checkTest1("t4r");

        // Test 2: load ch0=4 on the start cycle itself.
        bus.load_valid     = 1'b1;
        bus.load_ch        = 4'd0;
        bus.load_intensity = 4'd4;
        runFrame("t2");
        checkTrain("t2_ch0", 0, 16'h8888, 4);
        checkTrain("t2_ch1", 1, 16'hAAAA, 8);

        // Test 3: all intensities zero.
        for (int ch = 0; ch < 4; ch++) loadCh(ch, 0);
        runFrame("t3");
        check("t3_silent", orTrains(), 16'h0);

        // Test 5: asynchronous reset mid-RUN.
        loadCh(7, 9);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        check("t5_ch7_spike", bus.spike_out, 16'h0080);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_spk", bus.spike_out, 16'h0);
        check("t5_async_busy", bus.busy, 1'b0);
        check("t5_async_done", bus.frame_done, 1'b0);
        check("t5_async_ready", bus.load_ready, 1'b0);
        #2;
        reset = 1'b0;
        tick();
        runFrame("t5p");
        check("t5_post_silent", orTrains(), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
